// File: rtl/core_mem_resp_if.sv
// core_mem_resp_if: native instruction/data port bundle between the pipeline core and
// the memory responder.
//   master (core side)  : drives fetch/data requests, receives instr/data/stall/bus_err.
//   slave (memory side) : receives requests, drives responses and stalls.
// Signal names keep their _i/_o suffixes as seen from the responder.
interface core_mem_resp_if;
    logic        instr_rd_en_i;
    logic [63:0] pc_i;
    logic        mem_rd_en_i;
    logic [63:0] addr_mem_rd_i;
    logic        mem_wr_en_i;
    logic [63:0] addr_mem_wr_i;
    logic [63:0] data_mem_wr_i;
    logic [7:0]  strb_mem_wr_i;
    logic [31:0] instr_o;
    logic [63:0] addr_instr_o;
    logic [63:0] data_mem_o;
    logic        stall_if_o;
    logic        stall_mem_o;
    logic        bus_err_o;

    modport master (
        output instr_rd_en_i, pc_i, mem_rd_en_i, addr_mem_rd_i,
               mem_wr_en_i, addr_mem_wr_i, data_mem_wr_i, strb_mem_wr_i,
        input  instr_o, addr_instr_o, data_mem_o, stall_if_o, stall_mem_o, bus_err_o
    );

    modport slave (
        input  instr_rd_en_i, pc_i, mem_rd_en_i, addr_mem_rd_i,
               mem_wr_en_i, addr_mem_wr_i, data_mem_wr_i, strb_mem_wr_i,
        output instr_o, addr_instr_o, data_mem_o, stall_if_o, stall_mem_o, bus_err_o
    );
endinterface

// File: rtl/core_mem_resp.sv
// core_mem_resp: memory-side responder for the core's native fetch and data ports.
// One single-port 64-bit RAM serves both ports; each access takes WAIT+1 busy cycles
// followed by one response cycle, and the core is held off via stall_if_o/stall_mem_o.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - core_mem_resp_if.slave: fetch request (instr_rd_en_i, pc_i), data read
//          (mem_rd_en_i, addr_mem_rd_i), data write (mem_wr_en_i, addr_mem_wr_i,
//          data_mem_wr_i, strb_mem_wr_i); responses instr_o, addr_instr_o, data_mem_o,
//          stall_if_o, stall_mem_o, bus_err_o.
module core_mem_resp #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned WAIT       = 1,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input logic           clk,
    input logic           rst,
    core_mem_resp_if.slave bus
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {StIdle, StDBusy, StIBusy, StDResp, StIResp} state_e;

    state_e      state_q;
    logic [3:0]  wait_cnt_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  strb_q;
    logic        rd_q;
    logic        wr_q;

    logic [31:0] instr_q;
    logic [63:0] addr_instr_q;
    logic [63:0] data_q;
    logic        bus_err_q;

    logic [63:0] mem [Depth];

    logic                  data_req;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  out_of_range;
    logic                  issue;
    logic                  misaligned;
    logic                  ram_we;
    logic [63:0]           mem_word;

    assign data_req     = bus.mem_rd_en_i | bus.mem_wr_en_i;
    assign word_idx     = addr_q[DEPTH_LOG2+2:3];
    assign out_of_range = |addr_q[63:DEPTH_LOG2+3];
    assign issue        = (wait_cnt_q == 4'd0);
    assign misaligned   = |addr_q[1:0];
    assign mem_word     = mem[word_idx];

    // Reset wins over the commit so a write interrupted by rst never lands.
    assign ram_we = (state_q == StDBusy) && issue && wr_q && !out_of_range && !rst;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int k = 0; k < 8; k++) begin
                if (strb_q[k]) begin
                    mem[word_idx][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wait_cnt_q   <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            instr_q      <= NOP_INSTR;
            addr_instr_q <= '0;
            data_q       <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // Data access belongs to the older instruction, so it wins.
                    if (data_req) begin
                        addr_q     <= bus.mem_wr_en_i ? bus.addr_mem_wr_i : bus.addr_mem_rd_i;
                        wdata_q    <= bus.data_mem_wr_i;
                        strb_q     <= bus.strb_mem_wr_i;
                        rd_q       <= bus.mem_rd_en_i;
                        wr_q       <= bus.mem_wr_en_i;
                        wait_cnt_q <= 4'(WAIT);
                        state_q    <= StDBusy;
                    end else if (bus.instr_rd_en_i) begin
                        addr_q     <= bus.pc_i;
                        rd_q       <= 1'b0;
                        wr_q       <= 1'b0;
                        wait_cnt_q <= 4'(WAIT);
                        state_q    <= StIBusy;
                    end
                end
                StDBusy: begin
                    if (issue) begin
                        state_q <= StDResp;
                        // Read+write performs only the write and reports zero data.
                        if (rd_q) begin
                            data_q <= (out_of_range || wr_q) ? 64'd0 : mem_word;
                        end
                        bus_err_q <= out_of_range | (rd_q & wr_q);
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                StIBusy: begin
                    if (issue) begin
                        state_q      <= StIResp;
                        addr_instr_q <= addr_q;
                        if (misaligned) begin
                            instr_q <= NOP_INSTR;
                        end else if (out_of_range) begin
                            instr_q <= 32'd0;
                        end else begin
                            instr_q <= addr_q[2] ? mem_word[63:32] : mem_word[31:0];
                        end
                        bus_err_q <= misaligned | out_of_range;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                // Requests are not sampled here so a held level request is not reissued.
                StDResp, StIResp: state_q <= StIdle;
                default:          state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.stall_mem_o = (data_req && (state_q == StIdle)) || (state_q == StDBusy);
        bus.stall_if_o  = (bus.instr_rd_en_i &&
                           ((state_q == StIdle) || (state_q == StDBusy) ||
                            (state_q == StDResp))) ||
                          (state_q == StIBusy);
    end

    assign bus.instr_o      = instr_q;
    assign bus.addr_instr_o = addr_instr_q;
    assign bus.data_mem_o   = data_q;
    assign bus.bus_err_o    = bus_err_q;

endmodule
